run_control_unit: RTL and testbench
===================================

RUN_CONTROL_UNIT -- requirements
Module: run_control_unit

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles CoreReset is held after a launch (legal range 1..255).
REQ-002 Parameter CNT_WIDTH, default 8: width of the cycle limit and cycle counter.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  launch request; level-sampled.
REQ-006 Stop  input  1  external abort request; level-sampled.
REQ-007 Halt  input  1  halt indication from the controlled core; level-sampled.
REQ-008 Step  input  1  single-step request; rising-edge detected internally.
REQ-009 Mode  input  2  00 free-run, 01 run-N, 10 single-step, 11 reserved.
REQ-010 CycleLimit  input  CNT_WIDTH  run-N enable-cycle budget; latched at launch.
REQ-011 CoreReset  output  1  reset to the controlled core.
REQ-012 CoreEn  output  1  clock enable to the controlled core.
REQ-013 Busy  output  1  high while in RESET_HOLD, RUN or STEP_WAIT.
REQ-014 Done  output  1  high while in DONE.
REQ-015 CycleCount  output  CNT_WIDTH  number of cycles with CoreEn=1 since the last launch.

Function
REQ-016 All outputs SHALL be registered; the FSM states SHALL be IDLE, RESET_HOLD, RUN, STEP_WAIT and DONE.
REQ-017 In IDLE: CoreReset=1, CoreEn=0, Busy=0, Done=0, CycleCount is held.
REQ-018 Start=1 in IDLE or DONE with Mode!=11 SHALL latch Mode and CycleLimit, clear CycleCount and enter RESET_HOLD; Start with Mode=11 SHALL be ignored.
REQ-019 RESET_HOLD SHALL keep CoreReset=1 and CoreEn=0 for exactly RST_CYCLES cycles, then exit to RUN (modes 00/01) or STEP_WAIT (mode 10), with CoreReset=0 from the exit edge onward.
REQ-020 Run-N with latched limit 0 SHALL exit RESET_HOLD directly to DONE with zero CoreEn cycles.
REQ-021 In RUN: CoreEn=1 every cycle; CycleCount SHALL increment by 1 on each edge at which CoreEn=1.
REQ-022 Run-N: CoreEn SHALL be high for exactly the latched limit cycles, then the unit SHALL enter DONE with CycleCount equal to that limit.
REQ-023 Free-run: CycleCount SHALL saturate at 2^CNT_WIDTH-1 without wrap-around, and the unit SHALL remain in RUN.
REQ-024 STEP_WAIT: each Step rising edge SHALL produce exactly one CoreEn=1 cycle, starting the cycle after the edge is sampled; a held Step SHALL yield one pulse only.
REQ-025 Stop=1 or Halt=1 sampled in RUN or STEP_WAIT SHALL force CoreEn=0 from the next edge and enter DONE; CycleCount SHALL include only the cycles CoreEn was actually high.
REQ-026 Stop or Halt sampled in the same cycle the run-N limit is reached SHALL give the same result as reaching the limit alone.
REQ-027 Stop and Halt SHALL be ignored in IDLE, RESET_HOLD and DONE.
REQ-028 In DONE: CoreReset=0, CoreEn=0, Done=1, Busy=0, CycleCount held; Start SHALL relaunch per REQ-018.
REQ-029 CycleLimit and Mode changes after launch SHALL have no effect until the next launch.

Reset
REQ-030 Reset=1 at any edge, including mid-run, SHALL put the unit in IDLE with CoreReset=1, CoreEn=0, Busy=0, Done=0, CycleCount=0 and the Step edge detector cleared; Reset SHALL take priority over all other inputs.

Verification
REQ-031 Run-N: Mode=01, CycleLimit=7, Start pulse -> CoreReset high 2 cycles, CoreEn high exactly 7 cycles, then Done=1 and CycleCount=7.
REQ-032 Stop: Mode=00, Stop asserted after 5 CoreEn cycles -> CoreEn low the next cycle, Done=1, CycleCount=5.
REQ-033 Single-step: Mode=10, Step held high for 4 cycles, then 2 further single-cycle pulses -> 3 CoreEn pulses total, CycleCount=3; Halt -> Done=1.
REQ-034 Boundaries: CycleLimit=0 -> Done=1 after RESET_HOLD with CycleCount=0; free-run held for 300 cycles -> CycleCount=255, unit still in RUN.
REQ-035 Reset mid-run: Reset during RUN at CycleCount=3 -> next cycle IDLE, CoreReset=1, CycleCount=0; Start with Mode=11 -> no state change.

Source files
------------

// File: rtl/run_control_unit.sv
// Run controller for a slave core: holds the core in reset after a launch, then
// gates its clock enable in free-run, run-N or single-step mode until done/abort.
module run_control_unit #(
    parameter int RST_CYCLES = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 halt,
    input  logic                 step,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] cycle_limit,
    output logic                 core_reset,
    output logic                 core_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RESET_HOLD = 3'd1;
    localparam logic [2:0] RUN        = 3'd2;
    localparam logic [2:0] STEP_WAIT  = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    localparam logic [1:0] MODE_RUNN = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [7:0]           HOLD_LAST = 8'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [2:0]           state, state_nx;
    logic [7:0]           hold_cnt, hold_nx;
    logic [1:0]           mode_q, mode_nx;
    logic [CNT_WIDTH-1:0] limit_q, limit_nx;
    logic [CNT_WIDTH-1:0] count_nx, count_inc;
    logic                 core_reset_nx, core_en_nx, busy_nx, done_nx;
    logic                 step_q, step_rise, abort;

    assign step_rise = step & ~step_q;
    assign abort     = stop | halt;
    assign count_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nx      = state;
        hold_nx       = hold_cnt;
        mode_nx       = mode_q;
        limit_nx      = limit_q;
        core_reset_nx = core_reset;
        core_en_nx    = 1'b0;
        count_nx      = core_en ? count_inc : cycle_count;

        case (state)
            IDLE, DONE: begin
                if (start && mode != MODE_RSVD) begin
                    state_nx      = RESET_HOLD;
                    hold_nx       = '0;
                    mode_nx       = mode;
                    limit_nx      = cycle_limit;
                    count_nx      = '0;
                    core_reset_nx = 1'b1;
                end
            end
            RESET_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    core_reset_nx = 1'b0;
                    if (mode_q == MODE_STEP) begin
                        state_nx = STEP_WAIT;
                    end else if (mode_q == MODE_RUNN && limit_q == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx   = RUN;
                        core_en_nx = 1'b1;
                    end
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            RUN: begin
                // Reaching the run-N budget wins over a simultaneous abort; both end in DONE.
                if (mode_q == MODE_RUNN && count_inc == limit_q) begin
                    state_nx = DONE;
                end else if (abort) begin
                    state_nx = DONE;
                end else begin
                    core_en_nx = 1'b1;
                end
            end
            STEP_WAIT: begin
                if (abort) begin
                    state_nx = DONE;
                end else begin
                    core_en_nx = step_rise;
                end
            end
            default: begin
                state_nx      = IDLE;
                core_reset_nx = 1'b1;
            end
        endcase

        busy_nx = (state_nx == RESET_HOLD) || (state_nx == RUN) || (state_nx == STEP_WAIT);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            mode_q      <= '0;
            limit_q     <= '0;
            step_q      <= 1'b0;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            mode_q      <= mode_nx;
            limit_q     <= limit_nx;
            step_q      <= step;
            core_reset  <= core_reset_nx;
            core_en     <= core_en_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            cycle_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_run_control_unit.sv
// Randomized bench for run_control_unit: builds a per-cycle expected trace from
// the run rules for each launch, then replays the stimulus and compares.
module tb_run_control_unit;

    localparam int RST = 2;
    localparam int W   = 8;
    localparam int CNT_MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset, start, stop, halt, step;
    logic [1:0]   mode;
    logic [W-1:0] cycle_limit;
    logic         core_reset, core_en, busy, done;
    logic [W-1:0] cycle_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] expCtl[$];
    int         expCnt[$];
    logic       drvStop[$], drvHalt[$], drvStep[$], drvStart[$];
    logic [1:0] drvMode[$];
    logic       stepPat[$];

    run_control_unit #(.RST_CYCLES(RST), .CNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .halt(halt),
        .step(step), .mode(mode), .cycle_limit(cycle_limit),
        .core_reset(core_reset), .core_en(core_en), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] rmode();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic clearQ();
        expCtl.delete(); expCnt.delete();
        drvStop.delete(); drvHalt.delete(); drvStep.delete();
        drvStart.delete(); drvMode.delete();
    endtask

    // ctl is {core_reset, core_en, busy, done}
    task automatic pushSlot(input logic [3:0] ctl, input int cnt, input logic sp, input logic hl,
                            input logic st, input logic sr, input logic [1:0] md);
        expCtl.push_back(ctl); expCnt.push_back(cnt);
        drvStop.push_back(sp); drvHalt.push_back(hl); drvStep.push_back(st);
        drvStart.push_back(sr); drvMode.push_back(md);
    endtask

    // abortAfter=0 means no abort; a free run without abort is observed for observeRun cycles only
    task automatic buildRun(input logic [1:0] m, input int limit, input int abortAfter, input int observeRun);
        int n;
        logic ab, which;
        clearQ();
        for (int h = 0; h < RST; h++)
            pushSlot(4'b1010, 0, rbit(), rbit(), rbit(), rbit(), rmode());
        if (m == 2'b01)
            n = (abortAfter != 0 && abortAfter < limit) ? abortAfter : limit;
        else
            n = (abortAfter != 0) ? abortAfter : observeRun;
        for (int k = 1; k <= n; k++) begin
            ab    = (abortAfter == k);
            which = rbit();
            if (ab)
                pushSlot(4'b0110, sat(k - 1), which, !which, rbit(), rbit(), rmode());
            else if (m == 2'b01 && k == limit)
                pushSlot(4'b0110, sat(k - 1), rbit(), rbit(), rbit(), rbit(), rmode());
            else
                pushSlot(4'b0110, sat(k - 1), 1'b0, 1'b0, rbit(), rbit(), rmode());
        end
        if (m == 2'b01 || abortAfter != 0) begin
            for (int d = 0; d < 4; d++) begin
                logic sr;
                sr = rbit();
                pushSlot(4'b0001, sat(n), rbit(), rbit(), rbit(), sr, sr ? 2'b11 : rmode());
            end
        end
    endtask

    // Step pattern comes from stepPat; halt is raised on its last entry
    task automatic buildStep(input logic randHold);
        logic prev, pending, s, last;
        int cnt;
        clearQ();
        prev = 1'b0;
        for (int h = 0; h < RST; h++) begin
            s = randHold ? rbit() : 1'b0;
            pushSlot(4'b1010, 0, rbit(), rbit(), s, rbit(), rmode());
            prev = s;
        end
        pending = 1'b0;
        cnt     = 0;
        for (int j = 0; j < stepPat.size(); j++) begin
            last = (j == stepPat.size() - 1);
            s    = stepPat[j];
            pushSlot({1'b0, pending, 1'b1, 1'b0}, cnt, 1'b0, last, s, rbit(), rmode());
            if (pending) cnt++;
            pending = s && !prev && !last;
            prev    = s;
        end
        for (int d = 0; d < 4; d++)
            pushSlot(4'b0001, cnt, rbit(), rbit(), rbit(), 1'b0, rmode());
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [W-1:0] lim);
        mode = m; cycle_limit = lim; start = 1'b1;
        stop = 1'b0; halt = 1'b0; step = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < expCtl.size(); i++) begin
            checkOutput($sformatf("ctl[m%0d,%0d]", m, i),
                        32'({core_reset, core_en, busy, done}), 32'(expCtl[i]));
            checkOutput($sformatf("cnt[m%0d,%0d]", m, i), 32'(cycle_count), 32'(expCnt[i]));
            stop  = drvStop[i];  halt = drvHalt[i]; step = drvStep[i];
            start = drvStart[i]; mode = drvMode[i];
            cycle_limit = W'($urandom_range(0, CNT_MAX));
            if (i < expCtl.size() - 1) tick();
        end
        start = 1'b0; stop = 1'b0; halt = 1'b0; step = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ctl"}, 32'({core_reset, core_en, busy, done}), 32'(4'b1000));
        checkOutput({tag, "_cnt"}, 32'(cycle_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; stop = 1'b1; halt = 1'b0; step = 1'b1;
        mode = 2'b01; cycle_limit = 8'd9;
        tick();
        checkIdle("rst0");
        tick();
        checkIdle("rst1");
        reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        tick();
        checkIdle("idle");

        buildRun(2'b01, 7, 0, 0);
        applyStimulus(2'b01, 8'd7);

        buildRun(2'b00, 0, 5, 0);
        applyStimulus(2'b00, 8'd3);

        stepPat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        buildStep(1'b0);
        applyStimulus(2'b10, 8'd0);

        buildRun(2'b01, 0, 0, 0);
        applyStimulus(2'b01, 8'd0);

        buildRun(2'b00, 0, 300, 0);
        applyStimulus(2'b00, 8'd0);

        for (int it = 0; it < 12; it++) begin
            int sel, lim, ab, len;
            sel = $urandom_range(0, 2);
            case (sel)
                0: begin
                    ab = $urandom_range(1, 20);
                    buildRun(2'b00, 0, ab, 0);
                    applyStimulus(2'b00, W'($urandom_range(0, CNT_MAX)));
                end
                1: begin
                    lim = $urandom_range(0, 15);
                    ab  = $urandom_range(0, lim + 3);
                    buildRun(2'b01, lim, ab, 0);
                    applyStimulus(2'b01, W'(lim));
                end
                default: begin
                    len = $urandom_range(4, 16);
                    stepPat.delete();
                    for (int j = 0; j < len; j++) stepPat.push_back(rbit());
                    buildStep(1'b1);
                    applyStimulus(2'b10, W'($urandom_range(0, CNT_MAX)));
                end
            endcase
        end

        buildRun(2'b00, 0, 0, 4);
        applyStimulus(2'b00, 8'd0);
        reset = 1'b1;
        tick();
        checkIdle("midrst");
        reset = 1'b0;
        tick();
        checkIdle("postrst");
        mode = 2'b11; start = 1'b1;
        tick();
        checkIdle("rsvd0");
        tick();
        checkIdle("rsvd1");
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
